// File: rtl/add_unpack_align.sv
// add_unpack_align: front end of the sequential binary32 adder.
// Unpacks two operands, orders them by effective exponent and aligns the
// smaller fraction to the larger one by right-shifting at most SHIFT_STEP
// bits per cycle. Bit 0 of each fraction is a sticky bit. The aligned pair is
// then held for the downstream normalize/round/pack stage.
module add_unpack_align #(
  parameter int unsigned SHIFT_STEP = 4
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic [2:0]  frm_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  exponent_max_out,
  output logic        sign_l_out,
  output logic        sign_s_out,
  output logic [25:0] frac_l_out,
  output logic [25:0] frac_s_out,
  output logic        swap_out,
  output logic        special_out,
  output logic [2:0]  frm_out
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  localparam logic [4:0] STEP    = 5'(SHIFT_STEP);
  localparam logic [4:0] REM_MAX = 5'd27;

  // A right shift of k bits. Every bit shifted out, plus the old bit 0,
  // is ORed into the new bit 0.
  function automatic logic [25:0] shr_sticky(input logic [25:0] f, input logic [4:0] k);
    logic [25:0] mask;
    mask = (26'd1 << k) - 26'd1;
    return (f >> k) | {25'd0, |(f & mask)};
  endfunction

  state_e      state_q, state_d;
  logic        in_ready_q, in_ready_d;
  logic        out_valid_q, out_valid_d;
  logic [7:0]  exp_max_q, exp_max_d;
  logic        sign_l_q, sign_l_d;
  logic        sign_s_q, sign_s_d;
  logic [25:0] frac_l_q, frac_l_d;
  logic [25:0] frac_s_q, frac_s_d;
  logic        swap_q, swap_d;
  logic        special_q, special_d;
  logic [2:0]  frm_q, frm_d;
  logic [4:0]  rem_q, rem_d;

  // Unpacked and ordered view of the operands currently on the inputs
  logic [7:0]  exp_a_s, exp_b_s, exp_l_s, exp_s_s, diff_s;
  logic [25:0] frac_a_s, frac_b_s;
  logic        b_larger_s, special_s;
  logic [4:0]  rem_init_s, k_s, rem_next_s;

  // Unpack both operands, pick the larger exponent, saturate the distance
  always_comb begin
    exp_a_s    = (op_a[30:23] == 8'd0) ? 8'd1 : op_a[30:23];
    exp_b_s    = (op_b[30:23] == 8'd0) ? 8'd1 : op_b[30:23];
    frac_a_s   = {(op_a[30:23] != 8'd0), op_a[22:0], 2'b00};
    frac_b_s   = {(op_b[30:23] != 8'd0), op_b[22:0], 2'b00};
    special_s  = (op_a[30:23] == 8'hFF) || (op_b[30:23] == 8'hFF);
    b_larger_s = (exp_b_s > exp_a_s);
    exp_l_s    = b_larger_s ? exp_b_s : exp_a_s;
    exp_s_s    = b_larger_s ? exp_a_s : exp_b_s;
    diff_s     = exp_l_s - exp_s_s;
    if (diff_s > 8'd27) begin
      rem_init_s = REM_MAX;
    end else begin
      rem_init_s = diff_s[4:0];
    end
  end

  // Per-cycle shift amount, limited by what is still left to shift
  always_comb begin
    if (rem_q < STEP) begin
      k_s = rem_q;
    end else begin
      k_s = STEP;
    end
    rem_next_s = rem_q - k_s;
  end

  // Next-state and datapath update
  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    exp_max_d   = exp_max_q;
    sign_l_d    = sign_l_q;
    sign_s_d    = sign_s_q;
    frac_l_d    = frac_l_q;
    frac_s_d    = frac_s_q;
    swap_d      = swap_q;
    special_d   = special_q;
    frm_d       = frm_q;
    rem_d       = rem_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid && in_ready_q) begin
          exp_max_d = exp_l_s;
          sign_l_d  = b_larger_s ? op_b[31] : op_a[31];
          sign_s_d  = b_larger_s ? op_a[31] : op_b[31];
          frac_l_d  = b_larger_s ? frac_b_s : frac_a_s;
          frac_s_d  = b_larger_s ? frac_a_s : frac_b_s;
          swap_d    = b_larger_s;
          special_d = special_s;
          frm_d     = frm_in;
          if (special_s || (rem_init_s == 5'd0)) begin
            rem_d       = 5'd0;
            state_d     = S_DONE;
            out_valid_d = 1'b1;
          end else begin
            rem_d   = rem_init_s;
            state_d = S_SHIFT;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SHIFT: begin
        frac_s_d = shr_sticky(frac_s_q, k_s);
        rem_d    = rem_next_s;
        if (rem_next_s == 5'd0) begin
          state_d     = S_DONE;
          out_valid_d = 1'b1;
        end else begin
          state_d = S_SHIFT;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d     = S_IDLE;
          out_valid_d = 1'b0;
        end else begin
          state_d = S_DONE;
        end
      end
      default: begin
        state_d     = S_IDLE;
        out_valid_d = 1'b0;
        rem_d       = 5'd0;
      end
    endcase
    in_ready_d = (state_d == S_IDLE);
  end

  // State and output registers; reset drops any operation in flight
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q     <= S_IDLE;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      exp_max_q   <= 8'd0;
      sign_l_q    <= 1'b0;
      sign_s_q    <= 1'b0;
      frac_l_q    <= 26'd0;
      frac_s_q    <= 26'd0;
      swap_q      <= 1'b0;
      special_q   <= 1'b0;
      frm_q       <= 3'd0;
      rem_q       <= 5'd0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      exp_max_q   <= exp_max_d;
      sign_l_q    <= sign_l_d;
      sign_s_q    <= sign_s_d;
      frac_l_q    <= frac_l_d;
      frac_s_q    <= frac_s_d;
      swap_q      <= swap_d;
      special_q   <= special_d;
      frm_q       <= frm_d;
      rem_q       <= rem_d;
    end
  end

  assign in_ready         = in_ready_q;
  assign out_valid        = out_valid_q;
  assign exponent_max_out = exp_max_q;
  assign sign_l_out       = sign_l_q;
  assign sign_s_out       = sign_s_q;
  assign frac_l_out       = frac_l_q;
  assign frac_s_out       = frac_s_q;
  assign swap_out         = swap_q;
  assign special_out      = special_q;
  assign frm_out          = frm_q;

endmodule

// File: tb/tb_add_unpack_align.sv
// Directed bench for add_unpack_align with a scoreboard queue of expected
// aligned results (SHIFT_STEP = 4).
module tb_add_unpack_align;

  typedef struct {
    logic [7:0]  e;
    logic        sl;
    logic        ss;
    logic [25:0] fl;
    logic [25:0] fs;
    logic        sw;
    logic        sp;
    logic [2:0]  frm;
    int          lat;
  } exp_t;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [2:0]  frm_in;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  exponent_max_out;
  logic        sign_l_out;
  logic        sign_s_out;
  logic [25:0] frac_l_out;
  logic [25:0] frac_s_out;
  logic        swap_out;
  logic        special_out;
  logic [2:0]  frm_out;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  add_unpack_align #(.SHIFT_STEP(4)) dut (
    .CLK(CLK), .nRST(nRST),
    .in_valid(in_valid), .in_ready(in_ready),
    .op_a(op_a), .op_b(op_b), .frm_in(frm_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .exponent_max_out(exponent_max_out),
    .sign_l_out(sign_l_out), .sign_s_out(sign_s_out),
    .frac_l_out(frac_l_out), .frac_s_out(frac_s_out),
    .swap_out(swap_out), .special_out(special_out), .frm_out(frm_out)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Reference: one-shot alignment by min(diff,27) with all lost bits sticky
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic [2:0] f);
    exp_t        r;
    logic [7:0]  ea, eb, el, es;
    logic [31:0] fa, fb, fsm, mask;
    int          d;
    ea = (a[30:23] == 8'd0) ? 8'd1 : a[30:23];
    eb = (b[30:23] == 8'd0) ? 8'd1 : b[30:23];
    fa = {6'd0, (a[30:23] != 8'd0), a[22:0], 2'b00};
    fb = {6'd0, (b[30:23] != 8'd0), b[22:0], 2'b00};
    r.sw  = (eb > ea);
    el    = r.sw ? eb : ea;
    es    = r.sw ? ea : eb;
    r.sp  = (a[30:23] == 8'hFF) || (b[30:23] == 8'hFF);
    r.e   = el;
    r.sl  = r.sw ? b[31] : a[31];
    r.ss  = r.sw ? a[31] : b[31];
    r.fl  = r.sw ? fb[25:0] : fa[25:0];
    fsm   = r.sw ? fa : fb;
    r.frm = f;
    d = int'(el) - int'(es);
    if (d > 27) d = 27;
    if (r.sp) begin
      r.fs  = fsm[25:0];
      r.lat = 0;
    end else begin
      mask  = (32'd1 << d) - 32'd1;
      fsm   = (fsm >> d) | {31'd0, |(fsm & mask)};
      r.fs  = fsm[25:0];
      r.lat = (d + 3) / 4;
    end
    return r;
  endfunction

  task automatic check_out(input exp_t x);
    chk("exp_max", 32'(exponent_max_out), 32'(x.e));
    chk("sign_l",  32'(sign_l_out),       32'(x.sl));
    chk("sign_s",  32'(sign_s_out),       32'(x.ss));
    chk("frac_l",  32'(frac_l_out),       32'(x.fl));
    chk("frac_s",  32'(frac_s_out),       32'(x.fs));
    chk("swap",    32'(swap_out),         32'(x.sw));
    chk("special", 32'(special_out),      32'(x.sp));
    chk("frm",     32'(frm_out),          32'(x.frm));
  endtask

  // Drive one operation, wait for the result, compare against the scoreboard.
  // With hold set the result is left sitting in DONE.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [2:0] f,
                        input exp_t e, input bit hold);
    int   cyc;
    exp_t x;
    @(negedge CLK);
    op_a = a; op_b = b; frm_in = f; in_valid = 1'b1;
    chk("in_ready_pre", 32'(in_ready), 32'd1);
    sb.push_back(e);
    @(posedge CLK); #1;
    in_valid = 1'b0; op_a = $urandom; op_b = $urandom; frm_in = 3'($urandom);
    cyc = 0;
    while (out_valid !== 1'b1 && cyc < 100) begin
      @(posedge CLK); #1;
      cyc++;
    end
    if (sb.size() > 0) begin
      x = sb.pop_front();
      chk("latency", 32'(cyc), 32'(x.lat));
      check_out(x);
    end else begin
      chk("sb_nonempty", 32'd0, 32'd1);
    end
    if (!hold) begin
      @(posedge CLK); #1;
      chk("out_valid_after_hs", 32'(out_valid), 32'd0);
      chk("in_ready_after_hs",  32'(in_ready),  32'd1);
    end
  endtask

  exp_t e;
  logic [31:0] ra, rb;

  initial begin
    nRST = 1'b0; in_valid = 1'b0; op_a = 32'd0; op_b = 32'd0;
    frm_in = 3'd0; out_ready = 1'b1;
    #12;
    chk("rst_in_ready",  32'(in_ready),   32'd0);
    chk("rst_out_valid", 32'(out_valid),  32'd0);
    chk("rst_frac_l",    32'(frac_l_out), 32'd0);
    chk("rst_exp",       32'(exponent_max_out), 32'd0);
    @(negedge CLK); nRST = 1'b1;
    @(posedge CLK); #1;
    chk("in_ready_idle", 32'(in_ready), 32'd1);

    // Equal operands: no alignment, result the cycle after accept
    e = '{8'h7F, 1'b0, 1'b0, 26'h2000000, 26'h2000000, 1'b0, 1'b0, 3'd1, 0};
    run_op(32'h3F800000, 32'h3F800000, 3'd1, e, 1'b0);
    // B larger by one
    e = '{8'h80, 1'b0, 1'b0, 26'h2000000, 26'h1000000, 1'b1, 1'b0, 3'd2, 1};
    run_op(32'h3F800000, 32'h40000000, 3'd2, e, 1'b0);
    // diff 24: guard + sticky survive
    e = '{8'h97, 1'b0, 1'b0, 26'h2000000, 26'h0000003, 1'b0, 1'b0, 3'd3, 6};
    run_op(32'h4B800000, 32'h3F800001, 3'd3, e, 1'b0);
    // diff 127 saturates at 27
    e = '{8'hFE, 1'b0, 1'b0, 26'h2000000, 26'h0000001, 1'b0, 1'b0, 3'd4, 7};
    run_op(32'h7F000000, 32'h3F800000, 3'd4, e, 1'b0);
    // Inf on A: special, no shift
    e = '{8'hFF, 1'b0, 1'b0, 26'h2000000, 26'h2000000, 1'b0, 1'b1, 3'd0, 0};
    run_op(32'h7F800000, 32'h3F800000, 3'd0, e, 1'b0);
    // -Inf on B: special with swap
    e = '{8'hFF, 1'b1, 1'b0, 26'h2000000, 26'h2000000, 1'b1, 1'b1, 3'd5, 0};
    run_op(32'h3F800000, 32'hFF800000, 3'd5, e, 1'b0);
    // Denormals tie at effective exp 1: A stays larger
    e = '{8'h01, 1'b0, 1'b1, 26'h0000004, 26'h0000008, 1'b0, 1'b0, 3'd6, 0};
    run_op(32'h00000001, 32'h80000002, 3'd6, e, 1'b0);
    // Negative larger operand
    e = '{8'h80, 1'b1, 1'b0, 26'h2000000, 26'h1000000, 1'b0, 1'b0, 3'd7, 1};
    run_op(32'hC0000000, 32'h3F800000, 3'd7, e, 1'b0);

    // A few model-checked operations with nearby exponents
    for (int i = 0; i < 6; i++) begin
      ra = $urandom;
      rb = {$urandom_range(1, 0), 8'(ra[30:23] - 8'($urandom_range(30, 0))), 23'($urandom)};
      if (ra[30:23] == 8'hFF) ra[30:23] = 8'hFE;
      if (rb[30:23] == 8'hFF) rb[30:23] = 8'h10;
      e = model(ra, rb, 3'(i));
      run_op(ra, rb, 3'(i), e, 1'b0);
    end

    // Backpressure: hold DONE, pulse in_valid with other operands
    out_ready = 1'b0;
    e = '{8'h80, 1'b0, 1'b0, 26'h2000000, 26'h1000000, 1'b1, 1'b0, 3'd2, 1};
    run_op(32'h3F800000, 32'h40000000, 3'd2, e, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      in_valid = (i % 2) == 0;
      op_a = 32'h4B800000; op_b = 32'h3F800001; frm_in = 3'd7;
      @(posedge CLK); #1;
      chk("bp_in_ready",  32'(in_ready),  32'd0);
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      check_out(e);
    end
    @(negedge CLK);
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge CLK); #1;
    chk("bp_release_valid", 32'(out_valid), 32'd0);
    chk("bp_release_ready", 32'(in_ready),  32'd1);
    for (int i = 0; i < 3; i++) begin
      @(posedge CLK); #1;
      chk("bp_no_capture", 32'(out_valid), 32'd0);
    end

    // Async reset in the middle of a shift
    @(negedge CLK);
    op_a = 32'h4B800000; op_b = 32'h3F800001; frm_in = 3'd3; in_valid = 1'b1;
    @(posedge CLK); #1;
    in_valid = 1'b0;
    @(posedge CLK); #1;
    chk("pre_rst_busy", 32'(in_ready), 32'd0);
    #2 nRST = 1'b0;
    #1;
    chk("arst_in_ready",  32'(in_ready),   32'd0);
    chk("arst_out_valid", 32'(out_valid),  32'd0);
    chk("arst_exp",       32'(exponent_max_out), 32'd0);
    chk("arst_frac_l",    32'(frac_l_out), 32'd0);
    chk("arst_frac_s",    32'(frac_s_out), 32'd0);
    chk("arst_frm",       32'(frm_out),    32'd0);
    @(negedge CLK); nRST = 1'b1;
    @(posedge CLK); #1;
    chk("post_rst_ready", 32'(in_ready),  32'd1);
    chk("post_rst_valid", 32'(out_valid), 32'd0);
    e = '{8'h97, 1'b0, 1'b0, 26'h2000000, 26'h0000003, 1'b0, 1'b0, 3'd3, 6};
    run_op(32'h4B800000, 32'h3F800001, 3'd3, e, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
